alu_exec: RTL and testbench

- Execute-stage ALU that consumes the 5-bit ALU control code from the ALU control decoder, plus two register/immediate operands.
- Produces a registered result, zero flag (for beq) and carry flag.
- Logic ops, add, diff and complement finish in one cycle. Shifts are iterative, one bit per cycle, so a barrel shifter is not needed.
- Start/busy/done handshake to the datapath controller FSM.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_shift_iter.sv | 65 ++++++
 rtl/alu_exec.sv | 124 ++++++++++++
 tb/tb_alu_exec.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes used by the ALU control decoder and
// the execute stage, plus the execute-stage FSM state encoding.
package alu_pkg;

  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_AND  = 5'b00001;
  localparam logic [4:0] ALU_XOR  = 5'b00010;
  localparam logic [4:0] ALU_SLL  = 5'b00011;
  localparam logic [4:0] ALU_SRL  = 5'b00111;
  localparam logic [4:0] ALU_SRA  = 5'b01111;
  localparam logic [4:0] ALU_COMP = 5'b01100;
  localparam logic [4:0] ALU_DIFF = 5'b10000;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } alu_state_e;

  // True for the three iterative shift operations
  function automatic logic is_shift(input logic [4:0] code);
    return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_shift_iter.sv
// Iterative one-bit-per-cycle shifter: owns the working register, the
// remaining-shift counter and the direction/fill selection.
module alu_shift_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [4:0]       op_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [SHW-1:0]   shamt_i,
  output logic [WIDTH-1:0] next_o,
  output logic             last_o
);

  logic [WIDTH-1:0] work_q, work_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [4:0]       op_q, op_d;

  // One-bit shift of the working register in the latched direction
  always_comb begin
    next_o = work_q;
    case (op_q)
      ALU_SLL: next_o = {work_q[WIDTH-2:0], 1'b0};
      ALU_SRA: next_o = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
      default: next_o = {1'b0, work_q[WIDTH-1:1]};
    endcase
  end

  // The step that brings the counter from 1 to 0 produces the final value
  assign last_o = (cnt_q == SHW'(1));

  // Load on accept, otherwise advance one bit per cycle while stepping
  always_comb begin
    work_d = work_q;
    cnt_d  = cnt_q;
    op_d   = op_q;
    if (load_i) begin
      work_d = data_i;
      cnt_d  = shamt_i;
      op_d   = op_i;
    end else if (step_i) begin
      work_d = next_o;
      cnt_d  = cnt_q - SHW'(1);
    end
  end

  // Shifter state registers, cleared by reset so an aborted shift leaves nothing behind
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      work_q <= '0;
      cnt_q  <= '0;
      op_q   <= ALU_SLL;
    end else begin
      work_q <= work_d;
      cnt_q  <= cnt_d;
      op_q   <= op_d;
    end
  end

endmodule

// File: rtl/alu_exec.sv
// Execute-stage ALU: single-cycle logic/arithmetic ops, iterative shifts,
// registered result/zero/carry and a start/busy/done handshake.
module alu_exec
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [4:0]       ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             busy,
  output logic             done
);

  alu_state_e       state_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             carry_q;
  logic             done_q;

  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   dif_w;
  logic [WIDTH-1:0] op_res;
  logic             op_cy;
  logic [SHW-1:0]   shamt;
  logic             shift_go;
  logic [WIDTH-1:0] sh_next;
  logic             sh_last;

  assign shamt = b[SHW-1:0];

  // Carries come from WIDTH+1-bit sums; diff is a + ~b + 1 so its carry means "no borrow"
  assign sum_w = {1'b0, a} + {1'b0, b};
  assign dif_w = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

  // Only a shift with a non-zero amount needs the iterative path
  assign shift_go = (state_q == IDLE) && start && is_shift(ctrl) && (shamt != '0);

  // Single-cycle result; a zero-amount shift simply passes a through
  always_comb begin
    op_res = '0;
    op_cy  = 1'b0;
    case (ctrl)
      ALU_ADD: begin
        op_res = sum_w[WIDTH-1:0];
        op_cy  = sum_w[WIDTH];
      end
      ALU_AND:  op_res = a & b;
      ALU_XOR:  op_res = a ^ b;
      ALU_COMP: op_res = ~a + {{(WIDTH-1){1'b0}}, 1'b1};
      ALU_DIFF: begin
        op_res = dif_w[WIDTH-1:0];
        op_cy  = dif_w[WIDTH];
      end
      ALU_SLL, ALU_SRL, ALU_SRA: op_res = a;
      default: op_res = '0;
    endcase
  end

  alu_shift_iter #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_shift (
    .clk     (clk),
    .rst     (rst),
    .load_i  (shift_go),
    .step_i  (state_q == SHIFT),
    .op_i    (ctrl),
    .data_i  (a),
    .shamt_i (shamt),
    .next_o  (sh_next),
    .last_o  (sh_last)
  );

  // Handshake FSM with registered result, flags and done pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (shift_go) begin
              state_q <= SHIFT;
            end else begin
              result_q <= op_res;
              zero_q   <= (op_res == '0);
              carry_q  <= op_cy;
              done_q   <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (sh_last) begin
            result_q <= sh_next;
            zero_q   <= (sh_next == '0);
            carry_q  <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= IDLE;
          end
        end
      endcase
    end
  end

  assign result = result_q;
  assign zero   = zero_q;
  assign carry  = carry_q;
  assign done   = done_q;
  assign busy   = (state_q == SHIFT);

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: behavioural model plus directed literals
// and randomized traffic.
module tb_alu_exec;

  localparam int W = 32;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [4:0]   ctrl  = 5'd0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic [W-1:0] result;
  logic         zero, carry, busy, done;

  int n_checks = 0;
  int n_errors = 0;

  // Model state
  logic [W-1:0] m_result, m_pend;
  logic         m_zero, m_carry, m_done, m_busy;
  int           m_left;

  logic [4:0]   codes [10];

  always #5 clk = ~clk;

  alu_exec #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst_n),
    .start  (start),
    .ctrl   (ctrl),
    .a      (a),
    .b      (b),
    .result (result),
    .zero   (zero),
    .carry  (carry),
    .busy   (busy),
    .done   (done)
  );

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference operation computed straight from the operation table
  function automatic void ref_op(input logic [4:0] c, input logic [W-1:0] x, input logic [W-1:0] y,
                                 output logic [W-1:0] r, output logic cy, output int lat);
    logic [W:0] w;
    int s;
    s   = int'(y[4:0]);
    r   = '0;
    cy  = 1'b0;
    lat = 0;
    case (c)
      5'b00000: begin w = {1'b0, x} + {1'b0, y}; r = w[W-1:0]; cy = w[W]; end
      5'b00001: r = x & y;
      5'b00010: r = x ^ y;
      5'b01100: r = 32'd0 - x;
      5'b10000: begin r = x - y; cy = (x >= y); end
      5'b00011: begin r = x << s; lat = s; end
      5'b00111: begin r = x >> s; lat = s; end
      5'b01111: begin r = $unsigned($signed(x) >>> s); lat = s; end
      default: r = '0;
    endcase
  endfunction

  // Behavioural model: one-cycle ops finish at the accept edge, shifts s edges later
  always @(posedge clk or negedge rst_n) begin
    logic [W-1:0] r;
    logic         cy;
    int           lat;
    if (!rst_n) begin
      m_result = '0; m_zero = 1'b0; m_carry = 1'b0; m_done = 1'b0;
      m_busy = 1'b0; m_left = 0; m_pend = '0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_result = m_pend; m_zero = (m_pend == 0); m_carry = 1'b0;
          m_done = 1'b1; m_busy = 1'b0;
        end
      end else if (start) begin
        ref_op(ctrl, a, b, r, cy, lat);
        if (lat > 0) begin
          m_busy = 1'b1; m_left = lat; m_pend = r;
        end else begin
          m_result = r; m_zero = (r == 0); m_carry = cy; m_done = 1'b1;
        end
      end
    end
  end

  // Compare DUT against the model every cycle out of reset
  always @(negedge clk) begin
    if (rst_n) begin
      chk("model.done",   W'(done),  W'(m_done));
      chk("model.busy",   W'(busy),  W'(m_busy));
      chk("model.result", result,    m_result);
      chk("model.zero",   W'(zero),  W'(m_zero));
      chk("model.carry",  W'(carry), W'(m_carry));
    end
  end

  task automatic issue(input logic [4:0] c, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    ctrl = c; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    int cyc;
    codes[0] = 5'b00000; codes[1] = 5'b00001; codes[2] = 5'b00010; codes[3] = 5'b01100;
    codes[4] = 5'b10000; codes[5] = 5'b00011; codes[6] = 5'b00111; codes[7] = 5'b01111;
    codes[8] = 5'b11111; codes[9] = 5'b01010;

    // Reset state
    @(negedge clk);
    chk("rst.result", result, '0);
    chk("rst.zero",   W'(zero),  '0);
    chk("rst.carry",  W'(carry), '0);
    chk("rst.busy",   W'(busy),  '0);
    chk("rst.done",   W'(done),  '0);
    #2 rst_n = 1'b1;

    // add with wrap-around
    issue(5'b00000, 32'hFFFF_FFFF, 32'd1);
    wait_done(5, cyc);
    chk("add.lat", cyc, 0);
    chk("add.result", result, 32'h0);
    chk("add.zero", W'(zero), 1);
    chk("add.carry", W'(carry), 1);

    // diff back-to-back
    @(negedge clk);
    ctrl = 5'b10000; a = 32'd5; b = 32'd5; start = 1'b1;
    @(negedge clk);
    chk("diff55.done", W'(done), 1);
    chk("diff55.result", result, 32'h0);
    chk("diff55.zero", W'(zero), 1);
    chk("diff55.carry", W'(carry), 1);
    a = 32'd3;
    @(negedge clk);
    start = 1'b0;
    chk("diff35.done", W'(done), 1);
    chk("diff35.result", result, 32'hFFFF_FFFE);
    chk("diff35.zero", W'(zero), 0);
    chk("diff35.carry", W'(carry), 0);

    // comp, and, xor, undefined
    issue(5'b01100, 32'd1, 32'h1234_5678);
    wait_done(5, cyc);
    chk("comp.result", result, 32'hFFFF_FFFF);
    issue(5'b00001, 32'hF0F0_F0F0, 32'hFF00_FF00);
    wait_done(5, cyc);
    chk("and.result", result, 32'hF000_F000);
    issue(5'b00010, 32'hF0F0_F0F0, 32'hFF00_FF00);
    wait_done(5, cyc);
    chk("xor.result", result, 32'h0FF0_0FF0);
    issue(5'b11111, 32'hDEAD_BEEF, 32'h1);
    wait_done(5, cyc);
    chk("undef.result", result, 32'h0);
    chk("undef.zero", W'(zero), 1);

    // sra with an ignored start pulse mid-shift
    issue(5'b01111, 32'h8000_0000, 32'd4);
    chk("sra.busy", W'(busy), 1);
    @(negedge clk);
    ctrl = 5'b00000; a = 32'd1; b = 32'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(10, cyc);
    chk("sra.lat", cyc + 2, 4);
    chk("sra.result", result, 32'hF800_0000);

    // srl, sll by 31, sll by zero amount
    issue(5'b00111, 32'h8000_0000, 32'd4);
    wait_done(10, cyc);
    chk("srl.lat", cyc, 4);
    chk("srl.result", result, 32'h0800_0000);
    issue(5'b00011, 32'd1, 32'd31);
    wait_done(40, cyc);
    chk("sll31.lat", cyc, 31);
    chk("sll31.result", result, 32'h8000_0000);
    issue(5'b00011, 32'h1234_5678, 32'h20);
    wait_done(5, cyc);
    chk("sll0.lat", cyc, 0);
    chk("sll0.result", result, 32'h1234_5678);

    // Reset in the 2nd cycle of a 10-bit shift
    issue(5'b00011, 32'd3, 32'd10);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst.busy", W'(busy), 0);
    chk("midrst.done", W'(done), 0);
    chk("midrst.result", result, 32'h0);
    #1 rst_n = 1'b1;
    issue(5'b00000, 32'd2, 32'd3);
    wait_done(5, cyc);
    chk("postrst.lat", cyc, 0);
    chk("postrst.result", result, 32'd5);

    // Randomized traffic checked by the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0);
      ctrl  = codes[$urandom_range(0, 9)];
      a     = $urandom;
      b     = $urandom;
      if ($urandom_range(0, 3) == 0) b = W'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = b;
    end
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("drain.busy", W'(busy), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
